switch_mcu_alu_upimm: RTL and testbench

SWITCH_MCU_ALU_UPIMM -- requirements
Module: switch_mcu_alu_upimm

---
 rtl/switch_mcu_alu_pkg.sv | 18 +
 rtl/switch_mcu_alu_upimm_calc.sv | 29 ++
 rtl/switch_mcu_alu_upimm.sv | 153 +++++++++++++++
 tb/tb_switch_mcu_alu_upimm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_mcu_alu_pkg.sv
// rtl/switch_mcu_alu_pkg.sv - shared encodings for the upper-immediate ALU unit
// Purpose: holds the LUI/AUIPC mode encoding and the unit's FSM state encoding
// so the top module and any future sibling units agree on them.
// Ports: none (package).
package switch_mcu_alu_pkg;

    typedef enum logic {
        MODE_LUI   = 1'b0,
        MODE_AUIPC = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/switch_mcu_alu_upimm_calc.sv
// rtl/switch_mcu_alu_upimm_calc.sv - combinational LUI/AUIPC result datapath
// Purpose: forms the U-type immediate (imm << 12, sign-extended from bit 31)
// and returns it directly for LUI or added to the PC for AUIPC.
// Ports:
//   mode_i   - 0 = LUI, 1 = AUIPC
//   imm_i    - 20-bit U-type immediate
//   pc_i     - PC of the instruction, XLEN bits
//   result_o - XLEN-bit result, wraps modulo 2^XLEN
module switch_mcu_alu_upimm_calc
    import switch_mcu_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            mode_i,
    input  logic [19:0]     imm_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] result_o
);

    logic signed [31:0] u32_s;
    logic [XLEN-1:0]    u_ext;

    assign u32_s = {imm_i, 12'h000};
    // Size-casting a signed value replicates bit 31 into the upper word on RV64.
    assign u_ext = XLEN'(u32_s);

    assign result_o = (mode_i == MODE_AUIPC) ? (pc_i + u_ext) : u_ext;

endmodule

// File: rtl/switch_mcu_alu_upimm.sv
// rtl/switch_mcu_alu_upimm.sv - LUI/AUIPC execution unit with register write-back
// Purpose: captures a U-type instruction when selected at the start cycle,
// computes the result one cycle later and holds a write request until the
// register file accepts it, then pulses done.
// Ports:
//   in_clk, in_rst  - clock, synchronous active-high reset
//   in_cycle_cnt    - instruction cycle counter; capture when == START_CYCLE
//   in_en           - decoder selects this unit (dropping it in CALC aborts)
//   in_mode         - 0 = LUI, 1 = AUIPC
//   in_imm_type_u   - U-type immediate
//   in_pc           - PC of the current instruction
//   in_rd           - destination register
//   in_wb_ready     - write port accepts the write
//   out_waddr/out_wen/out_wdata - registered write request (zero when idle)
//   out_busy        - unit holds an operation (CALC or WB)
//   out_done        - one-cycle completion pulse
module switch_mcu_alu_upimm
    import switch_mcu_alu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int START_CYCLE = 1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [3:0]        in_cycle_cnt,
    input  logic              in_en,
    input  logic              in_mode,
    input  logic [19:0]       in_imm_type_u,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wb_ready,
    output logic [REG_AW-1:0] out_waddr,
    output logic              out_wen,
    output logic [XLEN-1:0]   out_wdata,
    output logic              out_busy,
    output logic              out_done
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [19:0]         imm_q, imm_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic                wen_q, wen_d;
    logic [REG_AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result;

    switch_mcu_alu_upimm_calc #(
        .XLEN(XLEN)
    ) u_calc (
        .mode_i   (mode_q),
        .imm_i    (imm_q),
        .pc_i     (pc_q),
        .result_o (result)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LUI;
            imm_q   <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        wen_d   = wen_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wen_d   = 1'b0;
                waddr_d = '0;
                wdata_d = '0;
                if (in_en && (in_cycle_cnt == 4'(START_CYCLE))) begin
                    mode_d  = mode_e'(in_mode);
                    imm_d   = in_imm_type_u;
                    pc_d    = in_pc;
                    rd_d    = in_rd;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (!in_en) begin
                    // Decoder withdrew the instruction: drop it silently.
                    state_d = ST_IDLE;
                end else if (rd_q != '0) begin
                    wen_d   = 1'b1;
                    waddr_d = rd_q;
                    wdata_d = result;
                    state_d = ST_WB;
                end else begin
                    // x0 destination: nothing to write, complete immediately.
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                // in_en is deliberately ignored here; a committed write must land.
                if (in_wb_ready) begin
                    wen_d   = 1'b0;
                    waddr_d = '0;
                    wdata_d = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                wen_d   = 1'b0;
                waddr_d = '0;
                wdata_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign out_waddr = waddr_q;
    assign out_wen   = wen_q;
    assign out_wdata = wdata_q;
    assign out_busy  = busy_q;
    assign out_done  = done_q;

endmodule

// File: tb/tb_switch_mcu_alu_upimm.sv
// tb/tb_switch_mcu_alu_upimm.sv - self-checking bench for the LUI/AUIPC unit
module tb_switch_mcu_alu_upimm;

    logic        clk;
    logic        rst;
    logic [3:0]  cnt;
    logic        en;
    logic        mode;
    logic [19:0] imm;
    logic [31:0] pc;
    logic [63:0] pc64;
    logic [4:0]  rd;
    logic        ready;

    logic [4:0]  waddr32, waddr64;
    logic        wen32, wen64;
    logic [31:0] wdata32;
    logic [63:0] wdata64;
    logic        busy32, busy64, done32, done64;

    int checks = 0;
    int errors = 0;

    assign pc64 = {32'h0, pc};

    switch_mcu_alu_upimm #(.XLEN(32), .REG_AW(5), .START_CYCLE(1)) dut32 (
        .in_clk(clk), .in_rst(rst), .in_cycle_cnt(cnt), .in_en(en),
        .in_mode(mode), .in_imm_type_u(imm), .in_pc(pc), .in_rd(rd),
        .in_wb_ready(ready), .out_waddr(waddr32), .out_wen(wen32),
        .out_wdata(wdata32), .out_busy(busy32), .out_done(done32)
    );

    switch_mcu_alu_upimm #(.XLEN(64), .REG_AW(5), .START_CYCLE(1)) dut64 (
        .in_clk(clk), .in_rst(rst), .in_cycle_cnt(cnt), .in_en(en),
        .in_mode(mode), .in_imm_type_u(imm), .in_pc(pc64), .in_rd(rd),
        .in_wb_ready(ready), .out_waddr(waddr64), .out_wen(wen64),
        .out_wdata(wdata64), .out_busy(busy64), .out_done(done64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: an instruction is either absent, waiting
    // one cycle for its result, or waiting for the write port.
    typedef struct packed {
        bit        computing;
        bit        writing;
        bit        op_auipc;
        bit [19:0] op_imm;
        bit [63:0] op_pc;
        bit [4:0]  op_rd;
        bit        wen;
        bit [4:0]  waddr;
        bit [63:0] wdata;
        bit        done;
    } model_t;

    model_t m32, m64;
    bit     model_live = 1'b0;

    function automatic bit [63:0] upimm_value(bit auipc, bit [19:0] i, bit [63:0] p, int xlen);
        longint signed u;
        bit [63:0] r;
        u = longint'(int'({i, 12'h000}));
        r = auipc ? (p + 64'(u)) : 64'(u);
        if (xlen == 32) r = {32'h0, r[31:0]};
        return r;
    endfunction

    function automatic model_t step(model_t m, bit [63:0] p, int xlen);
        model_t n;
        n = m;
        n.done = 1'b0;
        if (rst) begin
            n = '0;
        end else if (m.computing) begin
            n.computing = 1'b0;
            if (en) begin
                if (m.op_rd != 0) begin
                    n.writing = 1'b1;
                    n.wen     = 1'b1;
                    n.waddr   = m.op_rd;
                    n.wdata   = upimm_value(m.op_auipc, m.op_imm, m.op_pc, xlen);
                end else begin
                    n.done = 1'b1;
                end
            end
        end else if (m.writing) begin
            if (ready) begin
                n.writing = 1'b0;
                n.wen = 1'b0;
                n.waddr = '0;
                n.wdata = '0;
                n.done = 1'b1;
            end
        end else if (en && cnt == 4'd1) begin
            n.computing = 1'b1;
            n.op_auipc  = mode;
            n.op_imm    = imm;
            n.op_pc     = p;
            n.op_rd     = rd;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m32 = step(m32, {32'h0, pc}, 32);
        m64 = step(m64, pc64, 64);
        model_live = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            chk("m32_wen",   64'(wen32),   64'(m32.wen));
            chk("m32_waddr", 64'(waddr32), 64'(m32.waddr));
            chk("m32_wdata", 64'(wdata32), m32.wdata);
            chk("m32_busy",  64'(busy32),  64'(m32.computing | m32.writing));
            chk("m32_done",  64'(done32),  64'(m32.done));
            chk("m64_wen",   64'(wen64),   64'(m64.wen));
            chk("m64_waddr", 64'(waddr64), 64'(m64.waddr));
            chk("m64_wdata", wdata64,      m64.wdata);
            chk("m64_busy",  64'(busy64),  64'(m64.computing | m64.writing));
            chk("m64_done",  64'(done64),  64'(m64.done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input bit md, input bit [19:0] im, input bit [31:0] p, input bit [4:0] r);
        en = 1'b1; cnt = 4'd1; mode = md; imm = im; pc = p; rd = r;
        tick();                 // capture edge T
        cnt = 4'd2;             // keep en high through CALC, no recapture
        tick();                 // edge T+1: result registered
    endtask

    initial begin
        rst = 1'b1; cnt = 4'd0; en = 1'b0; mode = 1'b0; imm = '0; pc = '0; rd = '0; ready = 1'b1;
        tick(); tick();
        chk("reset_wen", 64'(wen32), 64'd0);
        chk("reset_busy", 64'(busy64), 64'd0);
        chk("reset_wdata", wdata64, 64'd0);
        rst = 1'b0;
        tick();

        // LUI x5, 0x12345 with ready high
        start_op(1'b0, 20'h12345, 32'h0000_1000, 5'd5);
        en = 1'b0;
        chk("lui_wen", 64'(wen32), 64'd1);
        chk("lui_waddr", 64'(waddr32), 64'd5);
        chk("lui_wdata32", 64'(wdata32), 64'h0000_0000_1234_5000);
        chk("lui_wdata64", wdata64, 64'h0000_0000_1234_5000);
        tick();
        chk("lui_done", 64'(done32), 64'd1);
        chk("lui_wen_off", 64'(wen32), 64'd0);
        tick();
        chk("lui_done_once", 64'(done32), 64'd0);

        // AUIPC wrap
        start_op(1'b1, 20'h00002, 32'hFFFF_F000, 5'd7);
        en = 1'b0;
        chk("auipc_wrap32", 64'(wdata32), 64'h0000_0000_0000_1000);
        chk("auipc_wrap64", wdata64, 64'h0000_0001_0000_1000);
        tick(); tick();

        // LUI with negative immediate on RV64
        start_op(1'b0, 20'h80000, 32'h0, 5'd3);
        en = 1'b0;
        chk("lui_neg64", wdata64, 64'hFFFF_FFFF_8000_0000);
        chk("lui_neg32", 64'(wdata32), 64'h0000_0000_8000_0000);
        tick(); tick();

        // Backpressure: ready low for three cycles, stray capture attempt while busy
        ready = 1'b0;
        start_op(1'b1, 20'h00010, 32'h0000_0040, 5'd9);
        en = 1'b1; cnt = 4'd1; imm = 20'hFFFFF; rd = 5'd1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_wen", 64'(wen32), 64'd1);
            chk("bp_wdata", 64'(wdata32), 64'h0000_0000_0001_0040);
            chk("bp_waddr", 64'(waddr32), 64'd9);
            if (k == 2) begin en = 1'b0; ready = 1'b1; end
            tick();
        end
        chk("bp_done", 64'(done32), 64'd1);
        chk("bp_wen_off", 64'(wen32), 64'd0);
        tick();
        chk("bp_single_done", 64'(done32), 64'd0);
        chk("bp_idle", 64'(busy32), 64'd0);

        // rd = x0: no write, done right after CALC
        start_op(1'b0, 20'hABCDE, 32'h0, 5'd0);
        en = 1'b0;
        chk("x0_done", 64'(done32), 64'd1);
        chk("x0_wen", 64'(wen32), 64'd0);
        tick();
        chk("x0_done_once", 64'(done64), 64'd0);

        // Abort in CALC
        en = 1'b1; cnt = 4'd1; mode = 1'b0; imm = 20'h11111; rd = 5'd4;
        tick();
        en = 1'b0; cnt = 4'd2;
        tick();
        chk("abort_wen", 64'(wen32), 64'd0);
        chk("abort_done", 64'(done32), 64'd0);
        chk("abort_busy", 64'(busy32), 64'd0);

        // Wrong cycle count: no capture
        en = 1'b1; cnt = 4'd3;
        tick();
        chk("nocap_busy", 64'(busy32), 64'd0);
        en = 1'b0;
        tick();

        // Reset in WB drops the write
        ready = 1'b0;
        start_op(1'b0, 20'h00777, 32'h0, 5'd12);
        en = 1'b0;
        chk("rstwb_pending", 64'(wen32), 64'd1);
        rst = 1'b1;
        tick();
        chk("rstwb_wen", 64'(wen32), 64'd0);
        chk("rstwb_busy", 64'(busy32), 64'd0);
        chk("rstwb_done", 64'(done32), 64'd0);
        rst = 1'b0; ready = 1'b1;
        tick(); tick();
        chk("rstwb_nowrite", 64'(wen64), 64'd0);
        chk("rstwb_nodone", 64'(done64), 64'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
